prog_loader: RTL and testbench

//  Configuration-chain front end. Accepts a framed bitstream as 32-bit words over a valid/ready stream.

---
 rtl/prog_pkg.sv | 35 +++
 rtl/prog_loader_if.sv | 29 ++
 rtl/prog_cksum.sv | 31 +++
 rtl/prog_loader.sv | 155 +++++++++++++++
 tb/tb_prog_loader.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : prog_pkg                                                          |
// | Desc   : Shared types and header-field constants for the config chain.     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package prog_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LOAD = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } ld_state_t;

  localparam logic [15:0] PROG_MAGIC    = 16'hEF6A;
  localparam int          HDR_MAGIC_MSB = 31;
  localparam int          HDR_MAGIC_LSB = 16;
  localparam int          HDR_LEN_MSB   = 15;
  localparam int          HDR_LEN_LSB   = 0;

  // A header is usable only with the right magic and a length in 1..max_len.
  function automatic logic hdr_valid(input logic [31:0] hdr,
                                     input logic [15:0] magic,
                                     input logic [15:0] max_len);
    logic [15:0] w_len;
    w_len = hdr[HDR_LEN_MSB:HDR_LEN_LSB];
    return (hdr[HDR_MAGIC_MSB:HDR_MAGIC_LSB] == magic) &&
           (w_len != 16'd0) && (w_len <= max_len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : prog_loader_if                                                    |
// | Desc   : Start pulse plus valid/ready word stream feeding the loader.      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface prog_loader_if;

  logic        cfg_start;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;

  modport master (
    output cfg_start,
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_start,
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );

endinterface
`default_nettype wire

// File: rtl/prog_cksum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : prog_cksum                                                        |
// | Desc   : Mod-2^32 running sum of payload words, cleared per frame.         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module prog_cksum (
  input  wire logic        clk,
  input  wire logic        nres,
  input  wire logic        clr,
  input  wire logic        add_en,
  input  wire logic [31:0] data,
  output logic      [31:0] sum
);

  logic [31:0] r_sum;

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      r_sum <= 32'h0;
    end else if (clr) begin
      r_sum <= 32'h0;
    end else if (add_en) begin
      r_sum <= r_sum + data;
    end
  end

  assign sum = r_sum;

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : prog_loader                                                       |
// | Desc   : Frames a word stream into the crossbar shift chain (prog_o/shft). |
// |          Optional trailer checksum when PROG_CKSUM_EN is defined.          |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module prog_loader
  import prog_pkg::*;
#(
  parameter int          MAX_WORDS = 219,
  parameter logic [15:0] MAGIC     = PROG_MAGIC
) (
  input  wire logic        clk,
  input  wire logic        nres,
  prog_loader_if.slave     cfg,
  output logic      [31:0] prog_o,
  output logic             prog_shft,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err
);

  localparam int            CW        = $clog2(MAX_WORDS + 1);
  localparam logic [15:0]   c_max_len = 16'(MAX_WORDS);
  localparam logic [CW-1:0] c_one     = CW'(1);

  ld_state_t     r_state;
  ld_state_t     w_next;
  logic [CW-1:0] r_count;
  logic [31:0]   r_prog;
  logic          r_shft;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          w_ready;
  logic          w_accept;
  logic          w_hdr_ok;
  logic          w_last;
  logic          w_cksum_ok;

  assign w_accept = cfg.cfg_valid & w_ready;
  assign w_hdr_ok = hdr_valid(cfg.cfg_data, MAGIC, c_max_len);
  assign w_last   = (r_count == c_one);

`ifdef PROG_CKSUM_EN
  logic [31:0] w_sum;
  logic        w_sum_clr;
  logic        w_sum_add;

  assign w_sum_clr = (r_state == HDR);
  assign w_sum_add = (r_state == LOAD) && w_accept;

  prog_cksum u_cksum (
    .clk    (clk),
    .nres   (nres),
    .clr    (w_sum_clr),
    .add_en (w_sum_add),
    .data   (cfg.cfg_data),
    .sum    (w_sum)
  );

  assign w_cksum_ok = (cfg.cfg_data == w_sum);
`else
  assign w_cksum_ok = 1'b0;
`endif

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (cfg.cfg_start) w_next = HDR;
      HDR:  if (w_accept)      w_next = w_hdr_ok ? LOAD : ERR;
      LOAD: begin
        if (w_accept && w_last) begin
`ifdef PROG_CKSUM_EN
          w_next = CHK;
`else
          w_next = DONE;
`endif
        end
      end
      CHK:  if (w_accept)      w_next = w_cksum_ok ? DONE : ERR;
      DONE: w_next = IDLE;
      ERR:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      HDR, LOAD, CHK: w_ready = 1'b1;
      default:        w_ready = 1'b0;
    endcase
  end

  // prog_shft is a one-cycle strobe per accepted payload word; prog_o only moves with it.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      r_prog  <= 32'h0;
      r_shft  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      r_shft <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cfg.cfg_start) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_err  <= 1'b0;
          end
        end
        HDR: begin
          if (w_accept) r_count <= cfg.cfg_data[HDR_LEN_LSB +: CW];
        end
        LOAD: begin
          if (w_accept) begin
            r_prog  <= cfg.cfg_data;
            r_shft  <= 1'b1;
            r_count <= r_count - c_one;
          end
        end
        default: ;
      endcase
      if (w_next == DONE) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
      if (w_next == ERR) begin
        r_err  <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  assign cfg.cfg_ready = w_ready;
  assign prog_o        = r_prog;
  assign prog_shft     = r_shft;
  assign cfg_busy      = r_busy;
  assign cfg_done      = r_done;
  assign cfg_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_prog_loader                                                    |
// | Desc   : Scoreboard bench for prog_loader (trailer words if PROG_CKSUM_EN).|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_prog_loader;

  localparam int MAXW = 219;

  logic        clk  = 1'b0;
  logic        nres = 1'b0;
  logic [31:0] prog_o;
  logic        prog_shft;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_err;

  int          checks   = 0;
  int          failures = 0;
  int          pulses   = 0;
  int          run      = 0;
  int          max_run  = 0;
  logic [31:0] last_prog = 32'h0;
  logic [31:0] want;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  prog_loader_if bus ();

  prog_loader #(
    .MAX_WORDS (MAXW),
    .MAGIC     (16'hEF6A)
  ) dut (
    .clk       (clk),
    .nres      (nres),
    .cfg       (bus),
    .prog_o    (prog_o),
    .prog_shft (prog_shft),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  // Scoreboard: a word pushed on acceptance must appear with prog_shft at the very next negedge.
  always @(negedge clk) begin
    if (!nres) begin
      last_prog = 32'h0;
      run       = 0;
    end else begin
      checks++;
      if (prog_shft !== (exp_q.size() != 0)) begin
        failures++;
        $display("FAIL shft_timing: prog_shft=%b expected=%b t=%0t", prog_shft, exp_q.size() != 0, $time);
      end
      if (prog_shft === 1'b1) begin
        pulses++;
        run++;
        if (run > max_run) max_run = run;
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          checks++;
          if (prog_o !== want) begin
            failures++;
            $display("FAIL prog_word: prog_o=%h expected=%h t=%0t", prog_o, want, $time);
          end
        end
        last_prog = prog_o;
      end else begin
        run = 0;
        checks++;
        if (prog_o !== last_prog) begin
          failures++;
          $display("FAIL prog_hold: prog_o=%h expected=%h t=%0t", prog_o, last_prog, $time);
        end
      end
      checks++;
      if (cfg_done === 1'b1 && cfg_err === 1'b1) begin
        failures++;
        $display("FAIL flags_exclusive: done=%b err=%b expected not both 1", cfg_done, cfg_err);
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [31:0] d, input bit payload);
    bit ok = 1'b0;
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.cfg_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        if (payload) exp_q.push_back(d);
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: cfg_ready=%b expected=1", bus.cfg_ready);
    end
  endtask

  task automatic drop();
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.cfg_start = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (cfg_done === 1'b1 || cfg_err === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout: done=%b err=%b expected one of them 1", name, cfg_done, cfg_err);
    end
    @(negedge clk);
  endtask

  task automatic run_frame(input logic [15:0] len, input bit gap, input int mid_at);
    logic [31:0] d;
    logic [31:0] sum;
    sum = 32'h0;
    pulse_start();
    send({16'hEF6A, len}, 1'b0);
    for (int i = 0; i < int'(len); i++) begin
      d   = $urandom;
      sum = sum + d;
      send(d, 1'b1);
      if (gap) begin
        drop();
        if (i == mid_at) bus.cfg_start = 1'b1;
        @(negedge clk);
        bus.cfg_start = 1'b0;
      end
    end
`ifdef PROG_CKSUM_EN
    send(sum, 1'b0);
`endif
    drop();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (prog_o !== 32'h0)       begin failures++; $display("FAIL rst_prog_o: got=%h expected=0", prog_o); end
    checks++; if (prog_shft !== 1'b0)     begin failures++; $display("FAIL rst_shft: got=%b expected=0", prog_shft); end
    checks++; if (bus.cfg_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got=%b expected=0", bus.cfg_ready); end
    checks++; if (cfg_busy !== 1'b0)      begin failures++; $display("FAIL rst_busy: got=%b expected=0", cfg_busy); end
    checks++; if (cfg_done !== 1'b0)      begin failures++; $display("FAIL rst_done: got=%b expected=0", cfg_done); end
    checks++; if (cfg_err !== 1'b0)       begin failures++; $display("FAIL rst_err: got=%b expected=0", cfg_err); end
    @(negedge clk);
    nres = 1'b1;
    @(negedge clk);
    checks++; if (bus.cfg_ready !== 1'b0) begin failures++; $display("FAIL idle_ready: got=%b expected=0", bus.cfg_ready); end
  endtask

  task automatic test_basic();
    pulses = 0; max_run = 0;
    pulse_start();
    checks++; if (cfg_busy !== 1'b1)      begin failures++; $display("FAIL start_busy: got=%b expected=1", cfg_busy); end
    checks++; if (bus.cfg_ready !== 1'b1) begin failures++; $display("FAIL hdr_ready: got=%b expected=1", bus.cfg_ready); end
    send(32'hEF6A_0003, 1'b0);
    send(32'hAAAA_0001, 1'b1);
    send(32'hBBBB_0002, 1'b1);
    send(32'hCCCC_0003, 1'b1);
`ifdef PROG_CKSUM_EN
    send(32'hAAAA_0001 + 32'hBBBB_0002 + 32'hCCCC_0003, 1'b0);
`endif
    drop();
    wait_end("basic");
    checks++; if (cfg_done !== 1'b1)      begin failures++; $display("FAIL basic_done: got=%b expected=1", cfg_done); end
    checks++; if (cfg_err !== 1'b0)       begin failures++; $display("FAIL basic_err: got=%b expected=0", cfg_err); end
    checks++; if (cfg_busy !== 1'b0)      begin failures++; $display("FAIL basic_busy: got=%b expected=0", cfg_busy); end
    checks++; if (pulses !== 3)           begin failures++; $display("FAIL basic_pulses: got=%0d expected=3", pulses); end
    checks++; if (max_run !== 3)          begin failures++; $display("FAIL basic_b2b: run=%0d expected=3", max_run); end
    checks++; if (exp_q.size() !== 0)     begin failures++; $display("FAIL basic_pending: got=%0d expected=0", exp_q.size()); end
    checks++; if (bus.cfg_ready !== 1'b0) begin failures++; $display("FAIL basic_ready: got=%b expected=0", bus.cfg_ready); end
  endtask

  task automatic test_bad_magic();
    pulses = 0;
    pulse_start();
    send(32'h1234_0003, 1'b0);
    drop();
    wait_end("magic");
    checks++; if (cfg_err !== 1'b1)       begin failures++; $display("FAIL magic_err: got=%b expected=1", cfg_err); end
    checks++; if (cfg_done !== 1'b0)      begin failures++; $display("FAIL magic_done: got=%b expected=0", cfg_done); end
    checks++; if (pulses !== 0)           begin failures++; $display("FAIL magic_pulses: got=%0d expected=0", pulses); end
    checks++; if (bus.cfg_ready !== 1'b0) begin failures++; $display("FAIL magic_ready: got=%b expected=0", bus.cfg_ready); end
    checks++; if (cfg_busy !== 1'b0)      begin failures++; $display("FAIL magic_busy: got=%b expected=0", cfg_busy); end
  endtask

  task automatic test_len_bounds();
    logic [15:0] bad_len[2];
    bad_len[0] = 16'd0;
    bad_len[1] = 16'(MAXW + 1);
    for (int k = 0; k < 2; k++) begin
      pulses = 0;
      pulse_start();
      send({16'hEF6A, bad_len[k]}, 1'b0);
      drop();
      wait_end("len_bad");
      checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL len_err len=%0d: got=%b expected=1", bad_len[k], cfg_err); end
      checks++; if (pulses !== 0)     begin failures++; $display("FAIL len_pulses len=%0d: got=%0d expected=0", bad_len[k], pulses); end
    end
    pulses = 0;
    run_frame(16'(MAXW), 1'b0, -1);
    wait_end("len_max");
    checks++; if (cfg_done !== 1'b1)  begin failures++; $display("FAIL lenmax_done: got=%b expected=1", cfg_done); end
    checks++; if (cfg_err !== 1'b0)   begin failures++; $display("FAIL lenmax_err: got=%b expected=0", cfg_err); end
    checks++; if (pulses !== MAXW)    begin failures++; $display("FAIL lenmax_pulses: got=%0d expected=%0d", pulses, MAXW); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL lenmax_pending: got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_gaps();
    pulses = 0; max_run = 0;
    run_frame(16'd4, 1'b1, 1);
    wait_end("gaps");
    checks++; if (cfg_done !== 1'b1)  begin failures++; $display("FAIL gaps_done: got=%b expected=1", cfg_done); end
    checks++; if (cfg_err !== 1'b0)   begin failures++; $display("FAIL gaps_err: got=%b expected=0", cfg_err); end
    checks++; if (pulses !== 4)       begin failures++; $display("FAIL gaps_pulses: got=%0d expected=4", pulses); end
    checks++; if (max_run !== 1)      begin failures++; $display("FAIL gaps_run: got=%0d expected=1", max_run); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL gaps_pending: got=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_reset_midframe();
    pulses = 0;
    pulse_start();
    send(32'hEF6A_0005, 1'b0);
    send(32'h1111_1111, 1'b1);
    send(32'h2222_2222, 1'b1);
    drop();
    @(negedge clk);
    nres = 1'b0;
    #1;
    checks++; if (pulses !== 2)           begin failures++; $display("FAIL mid_pulses: got=%0d expected=2", pulses); end
    checks++; if (prog_o !== 32'h0)       begin failures++; $display("FAIL mid_prog_o: got=%h expected=0", prog_o); end
    checks++; if (prog_shft !== 1'b0)     begin failures++; $display("FAIL mid_shft: got=%b expected=0", prog_shft); end
    checks++; if (bus.cfg_ready !== 1'b0) begin failures++; $display("FAIL mid_ready: got=%b expected=0", bus.cfg_ready); end
    checks++; if (cfg_busy !== 1'b0)      begin failures++; $display("FAIL mid_busy: got=%b expected=0", cfg_busy); end
    checks++; if (cfg_done !== 1'b0)      begin failures++; $display("FAIL mid_done: got=%b expected=0", cfg_done); end
    checks++; if (cfg_err !== 1'b0)       begin failures++; $display("FAIL mid_err: got=%b expected=0", cfg_err); end
    exp_q.delete();
    @(negedge clk);
    nres = 1'b1;
    pulses = 0;
    run_frame(16'd3, 1'b0, -1);
    wait_end("reload");
    checks++; if (cfg_done !== 1'b1)  begin failures++; $display("FAIL reload_done: got=%b expected=1", cfg_done); end
    checks++; if (pulses !== 3)       begin failures++; $display("FAIL reload_pulses: got=%0d expected=3", pulses); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL reload_pending: got=%0d expected=0", exp_q.size()); end
  endtask

`ifdef PROG_CKSUM_EN
  task automatic test_cksum();
    logic [31:0] trailer[2];
    trailer[0] = 32'd6;
    trailer[1] = 32'd7;
    for (int k = 0; k < 2; k++) begin
      pulses = 0;
      pulse_start();
      send(32'hEF6A_0003, 1'b0);
      send(32'd1, 1'b1);
      send(32'd2, 1'b1);
      send(32'd3, 1'b1);
      send(trailer[k], 1'b0);
      drop();
      wait_end("cksum");
      checks++; if (cfg_done !== (k == 0)) begin failures++; $display("FAIL cksum_done trailer=%0d: got=%b expected=%b", trailer[k], cfg_done, k == 0); end
      checks++; if (cfg_err !== (k == 1))  begin failures++; $display("FAIL cksum_err trailer=%0d: got=%b expected=%b", trailer[k], cfg_err, k == 1); end
      checks++; if (pulses !== 3)          begin failures++; $display("FAIL cksum_pulses trailer=%0d: got=%0d expected=3", trailer[k], pulses); end
    end
  endtask
`endif

  initial begin
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = 32'h0;
    test_reset();
    test_basic();
    test_bad_magic();
    test_len_bounds();
    test_gaps();
    test_reset_midframe();
`ifdef PROG_CKSUM_EN
    test_cksum();
`endif
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
